// File: rtl/call_request_latch_if.sv
// Call-button bundle between the button panel/elevator side and the request latch.
// The slave modport is the latch; the master modport drives buttons, floor/door state and login.
interface call_request_latch_if #(
   parameter int FLOORS = 3
);
   localparam int CW = $clog2(2*FLOORS+1);

   logic [FLOORS-1:0] reqin_raw;
   logic [FLOORS-1:0] reqout_raw;
   logic [FLOORS-1:0] pres;
   logic [FLOORS-1:0] door;
   logic              movement;
   logic              logout;
   logic [FLOORS-1:0] reqin;
   logic [FLOORS-1:0] reqout;
   logic              pending;
   logic [CW-1:0]     req_count;
   logic              accepted;
   logic              rejected;

   modport slave (
      input  reqin_raw, reqout_raw, pres, door, movement, logout,
      output reqin, reqout, pending, req_count, accepted, rejected
   );

   modport master (
      output reqin_raw, reqout_raw, pres, door, movement, logout,
      input  reqin, reqout, pending, req_count, accepted, rejected
   );
endinterface

// File: rtl/call_request_latch.sv
// Synchronises and debounces cabin/hall call buttons and latches each press as a pending
// call until the elevator serves that floor (present and door open).
module call_request_latch #(
   parameter int FLOORS     = 3,
   parameter int DEB_CYCLES = 4,
   parameter int DEB_W      = 3
) (
   input  logic                 clk,
   input  logic                 rst,
   call_request_latch_if.slave  bus
);
   localparam int N  = 2*FLOORS;
   localparam int CW = $clog2(2*FLOORS+1);
   localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES-1);

   // Cabin buttons occupy [FLOORS-1:0], hall buttons [N-1:FLOORS]; both share one debounce path.
   logic [N-1:0]            sync1_q, sync2_q, deb_q, deb_d, flip, rise;
   logic [N-1:0][DEB_W-1:0] cnt_q, cnt_d;
   logic [FLOORS-1:0]       reqin_q, reqin_d, reqout_q, reqout_d;
   logic [FLOORS-1:0]       serve, cab_rise, hall_rise, cab_new, hall_new;
   logic                    accepted_q, accepted_d, rejected_q, rejected_d, cabin_ok;
   logic [CW-1:0]           count;

   always_comb begin
      cnt_d = '0;
      flip  = '0;
      for (int i = 0; i < N; i++) begin
         if (sync2_q[i] != deb_q[i]) begin
            if (cnt_q[i] == DEB_LAST) flip[i] = 1'b1;
            else                      cnt_d[i] = cnt_q[i] + DEB_W'(1);
         end
      end
      deb_d = deb_q ^ flip;
      rise  = flip & ~deb_q;
   end

   always_comb begin
      serve     = bus.pres & bus.door;
      cabin_ok  = bus.movement & ~bus.logout;
      cab_rise  = rise[FLOORS-1:0];
      hall_rise = rise[N-1:FLOORS];
      // Serving a floor beats a press debounced on the same edge.
      hall_new  = hall_rise & ~reqout_q & ~serve;
      cab_new   = cab_rise & ~reqin_q & ~serve & {FLOORS{cabin_ok}};
      reqout_d  = (reqout_q | hall_rise) & ~serve;
      reqin_d   = bus.logout ? '0 : (reqin_q | (cab_rise & {FLOORS{cabin_ok}})) & ~serve;
      accepted_d = |{hall_new, cab_new};
      rejected_d = (|(cab_rise & ~serve)) & ~cabin_ok;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync1_q    <= '0;
         sync2_q    <= '0;
         deb_q      <= '0;
         cnt_q      <= '0;
         reqin_q    <= '0;
         reqout_q   <= '0;
         accepted_q <= 1'b0;
         rejected_q <= 1'b0;
      end else begin
         sync1_q    <= {bus.reqout_raw, bus.reqin_raw};
         sync2_q    <= sync1_q;
         deb_q      <= deb_d;
         cnt_q      <= cnt_d;
         reqin_q    <= reqin_d;
         reqout_q   <= reqout_d;
         accepted_q <= accepted_d;
         rejected_q <= rejected_d;
      end
   end

   always_comb begin
      count = '0;
      for (int i = 0; i < FLOORS; i++)
         count = count + CW'(reqin_q[i]) + CW'(reqout_q[i]);
   end

   assign bus.reqin     = reqin_q;
   assign bus.reqout    = reqout_q;
   assign bus.pending   = |{reqin_q, reqout_q};
   assign bus.req_count = count;
   assign bus.accepted  = accepted_q;
   assign bus.rejected  = rejected_q;
endmodule

// File: tb/tb_call_request_latch.sv
// Directed bench: stimulus pushes the expected accepted/rejected pulse snapshot into a queue,
// a negedge monitor pops and compares whenever the DUT pulses.
module tb_call_request_latch;
   logic clk = 1'b0;
   logic rst = 1'b0;
   int   n_vec = 0;
   int   n_err = 0;

   typedef struct packed {
      logic       acc;
      logic       rej;
      logic [2:0] ri;
      logic [2:0] ro;
      logic [2:0] cnt;
   } exp_t;
   exp_t q[$];

   call_request_latch_if #(.FLOORS(3)) bus();

   call_request_latch #(.FLOORS(3), .DEB_CYCLES(4), .DEB_W(3)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic expect_pulse(input logic acc, input logic rej, input logic [2:0] ri,
                               input logic [2:0] ro, input logic [2:0] cnt);
      exp_t e;
      e.acc = acc; e.rej = rej; e.ri = ri; e.ro = ro; e.cnt = cnt;
      q.push_back(e);
   endtask

   // Monitor: every pulse must match the next queued expectation.
   always @(negedge clk) begin
      if (rst && (bus.accepted || bus.rejected)) begin
         n_vec++;
         if (q.size() == 0) begin
            n_err++;
            $display("FAIL pulse: unexpected acc=%0b rej=%0b reqin=%b reqout=%b",
                     bus.accepted, bus.rejected, bus.reqin, bus.reqout);
         end else begin
            exp_t e;
            e = q.pop_front();
            if ({bus.accepted, bus.rejected, bus.reqin, bus.reqout, bus.req_count} !== e) begin
               n_err++;
               $display("FAIL pulse: got acc=%0b rej=%0b ri=%b ro=%b cnt=%0d expected acc=%0b rej=%0b ri=%b ro=%b cnt=%0d",
                        bus.accepted, bus.rejected, bus.reqin, bus.reqout, bus.req_count,
                        e.acc, e.rej, e.ri, e.ro, e.cnt);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL timeout: bench did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      bus.reqin_raw = '0; bus.reqout_raw = '0; bus.pres = '0; bus.door = '0;
      bus.movement = 1'b0; bus.logout = 1'b0;
      tick(2);
      rst = 1'b1;
      tick(2);

      // 1: reset mid-debounce of hall floor 1
      bus.reqout_raw = 3'b010;
      tick(3);
      rst = 1'b0;
      #1;
      chk("rst_reqin",    8'(bus.reqin),     8'h0);
      chk("rst_reqout",   8'(bus.reqout),    8'h0);
      chk("rst_pending",  8'(bus.pending),   8'h0);
      chk("rst_count",    8'(bus.req_count), 8'h0);
      chk("rst_accepted", 8'(bus.accepted),  8'h0);
      chk("rst_rejected", 8'(bus.rejected),  8'h0);
      bus.reqout_raw = '0;
      tick(2);
      rst = 1'b1;
      tick(8);
      chk("rst_nolatch", 8'(bus.reqout), 8'h0);

      // 2: hall call floor 2, latency boundary at E0+4 / E0+5
      expect_pulse(1'b1, 1'b0, 3'b000, 3'b100, 3'd1);
      bus.reqout_raw = 3'b100;
      tick(5);
      chk("hall_early", 8'(bus.reqout), 8'h0);
      tick(1);
      chk("hall_reqout",  8'(bus.reqout),    8'h4);
      chk("hall_count",   8'(bus.req_count), 8'h1);
      chk("hall_pending", 8'(bus.pending),   8'h1);
      tick(4);
      bus.reqout_raw = '0;
      tick(8);
      chk("hall_release", 8'(bus.reqout), 8'h4);

      // 3: bounce shorter than the debounce window
      bus.movement = 1'b1;
      bus.reqin_raw = 3'b001; tick(3);
      bus.reqin_raw = 3'b000; tick(2);
      bus.reqin_raw = 3'b001; tick(3);
      bus.reqin_raw = 3'b000; tick(8);
      chk("bounce_reqin", 8'(bus.reqin), 8'h0);

      // 4: gating, then accepted press, then logout
      bus.movement = 1'b0;
      expect_pulse(1'b0, 1'b1, 3'b000, 3'b100, 3'd1);
      bus.reqin_raw = 3'b010; tick(6);
      chk("gate_reqin", 8'(bus.reqin), 8'h0);
      bus.reqin_raw = '0; tick(8);
      bus.movement = 1'b1;
      expect_pulse(1'b1, 1'b0, 3'b010, 3'b100, 3'd2);
      bus.reqin_raw = 3'b010; tick(6);
      chk("cab_reqin", 8'(bus.reqin), 8'h2);
      bus.reqin_raw = '0; tick(8);
      bus.logout = 1'b1; tick(1);
      bus.logout = 1'b0;
      chk("logout_reqin",  8'(bus.reqin),  8'h0);
      chk("logout_reqout", 8'(bus.reqout), 8'h4);

      // 5: serve floor 0 with reqin=011, reqout=001
      bus.pres = 3'b100; bus.door = 3'b100; tick(1);
      bus.pres = '0; bus.door = '0;
      chk("serve2_reqout", 8'(bus.reqout), 8'h0);
      expect_pulse(1'b1, 1'b0, 3'b011, 3'b000, 3'd2);
      bus.reqin_raw = 3'b011; tick(6);
      bus.reqin_raw = '0; tick(8);
      expect_pulse(1'b1, 1'b0, 3'b011, 3'b001, 3'd3);
      bus.reqout_raw = 3'b001; tick(6);
      bus.reqout_raw = '0; tick(8);
      chk("pre_serve", 8'({bus.reqin, bus.reqout}), 8'h19);
      bus.pres = 3'b001; bus.door = 3'b001; tick(1);
      bus.pres = '0; bus.door = '0;
      chk("serve_reqin",  8'(bus.reqin),     8'h2);
      chk("serve_reqout", 8'(bus.reqout),    8'h0);
      chk("serve_count",  8'(bus.req_count), 8'h1);

      // 6: hall press debounces on the same edge floor 0 is served
      bus.reqout_raw = 3'b001; tick(5);
      bus.pres = 3'b001; bus.door = 3'b001; tick(1);
      bus.pres = '0; bus.door = '0;
      chk("collide_reqout", 8'(bus.reqout), 8'h0);
      tick(3);
      bus.reqout_raw = '0; tick(8);
      chk("collide_after", 8'(bus.reqout), 8'h0);
      chk("collide_reqin", 8'(bus.reqin),  8'h2);

      tick(2);
      chk("queue_drained", 8'(q.size()), 8'h0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
